// File: rtl/riscv_ctrl_pkg.sv
// ============================================================================
// riscv_ctrl_pkg : shared encodings for the multi-cycle RV32I controller
// Revision 1.0
// ============================================================================
`default_nettype none

package riscv_ctrl_pkg;

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADR   = 4'd2,
    S_MEMREAD  = 4'd3,
    S_MEMWB    = 4'd4,
    S_MEMWRITE = 4'd5,
    S_EXECR    = 4'd6,
    S_EXECI    = 4'd7,
    S_ALUWB    = 4'd8,
    S_JAL      = 4'd9,
    S_JALR     = 4'd10,
    S_BRANCH   = 4'd11,
    S_LUI      = 4'd12,
    S_AUIPC    = 4'd13,
    S_TRAP     = 4'd14
  } state_t;

  localparam logic [3:0] ALU_ADD  = 4'd0;
  localparam logic [3:0] ALU_SUB  = 4'd1;
  localparam logic [3:0] ALU_AND  = 4'd2;
  localparam logic [3:0] ALU_OR   = 4'd3;
  localparam logic [3:0] ALU_XOR  = 4'd4;
  localparam logic [3:0] ALU_SLT  = 4'd5;
  localparam logic [3:0] ALU_SLTU = 4'd6;
  localparam logic [3:0] ALU_SLL  = 4'd7;
  localparam logic [3:0] ALU_SRL  = 4'd8;
  localparam logic [3:0] ALU_SRA  = 4'd9;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;

  localparam logic [2:0] IMM_I = 3'b000;
  localparam logic [2:0] IMM_S = 3'b001;
  localparam logic [2:0] IMM_B = 3'b010;
  localparam logic [2:0] IMM_J = 3'b011;
  localparam logic [2:0] IMM_U = 3'b100;

  localparam logic [1:0] RES_ALUOUT = 2'b00;
  localparam logic [1:0] RES_DATA   = 2'b01;
  localparam logic [1:0] RES_ALURES = 2'b10;

  // SRCA_ZERO lets LUI pass the immediate straight through an ADD.
  localparam logic [1:0] SRCA_PC    = 2'b00;
  localparam logic [1:0] SRCA_OLDPC = 2'b01;
  localparam logic [1:0] SRCA_RS1   = 2'b10;
  localparam logic [1:0] SRCA_ZERO  = 2'b11;

  localparam logic [1:0] SRCB_RS2  = 2'b00;
  localparam logic [1:0] SRCB_IMM  = 2'b01;
  localparam logic [1:0] SRCB_FOUR = 2'b10;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  localparam logic [1:0] CAUSE_NONE    = 2'b00;
  localparam logic [1:0] CAUSE_ILLEGAL = 2'b01;
  localparam logic [1:0] CAUSE_TIMEOUT = 2'b10;

  typedef struct packed {
    logic       adr_src;
    logic       mem_req;
    logic [1:0] result_src;
    logic [1:0] src_a;
    logic [1:0] src_b;
    logic [1:0] alu_op;
    logic       reg_write;
    logic       pc_write;
    logic       trap;
  } ctl_t;

  function automatic ctl_t moore_ctl(input state_t s);
    ctl_t c;
    c = '0;
    case (s)
      S_FETCH:    begin c.mem_req = 1'b1; c.src_a = SRCA_PC; c.src_b = SRCB_FOUR; c.result_src = RES_ALURES; end
      S_DECODE:   begin c.src_a = SRCA_OLDPC; c.src_b = SRCB_IMM; end
      S_MEMADR:   begin c.src_a = SRCA_RS1; c.src_b = SRCB_IMM; end
      S_MEMREAD,
      S_MEMWRITE: begin c.adr_src = 1'b1; c.mem_req = 1'b1; c.result_src = RES_ALUOUT; end
      S_MEMWB:    begin c.result_src = RES_DATA; c.reg_write = 1'b1; end
      S_EXECR:    begin c.src_a = SRCA_RS1; c.src_b = SRCB_RS2; c.alu_op = ALUOP_FUNCT; end
      S_EXECI:    begin c.src_a = SRCA_RS1; c.src_b = SRCB_IMM; c.alu_op = ALUOP_FUNCT; end
      S_ALUWB:    begin c.result_src = RES_ALUOUT; c.reg_write = 1'b1; end
      S_JAL:      begin c.src_a = SRCA_OLDPC; c.src_b = SRCB_FOUR; c.result_src = RES_ALUOUT; c.pc_write = 1'b1; end
      S_JALR:     begin c.src_a = SRCA_RS1; c.src_b = SRCB_IMM; c.result_src = RES_ALURES; c.pc_write = 1'b1; end
      S_BRANCH:   begin c.src_a = SRCA_RS1; c.src_b = SRCB_RS2; c.alu_op = ALUOP_SUB; c.result_src = RES_ALUOUT; end
      S_LUI:      begin c.src_a = SRCA_ZERO; c.src_b = SRCB_IMM; end
      S_AUIPC:    begin c.src_a = SRCA_OLDPC; c.src_b = SRCB_IMM; end
      S_TRAP:     c.trap = 1'b1;
      default:    c = '0;
    endcase
    return c;
  endfunction

  function automatic logic [2:0] imm_src(input logic [6:0] op);
    logic [2:0] r;
    case (op)
      OP_STORE:         r = IMM_S;
      OP_BRANCH:        r = IMM_B;
      OP_JAL:           r = IMM_J;
      OP_LUI, OP_AUIPC: r = IMM_U;
      default:          r = IMM_I;
    endcase
    return r;
  endfunction

endpackage

`default_nettype wire

// File: rtl/riscv_alu_dec.sv
// ============================================================================
// riscv_alu_dec : ALUOp/funct3/funct7b5 to ALUControl decode
// Revision 1.0
// ============================================================================
`default_nettype none

module riscv_alu_dec
  import riscv_ctrl_pkg::*;
(
  input  logic [1:0] alu_op_i,
  input  logic [2:0] funct3_i,
  input  logic       funct7b5_i,
  input  logic       rtype_i,
  output logic [3:0] alu_control_o
);

  always_comb begin
    alu_control_o = ALU_ADD;
    case (alu_op_i)
      ALUOP_ADD: alu_control_o = ALU_ADD;
      ALUOP_SUB: alu_control_o = ALU_SUB;
      default: begin
        case (funct3_i)
          // funct7b5 on an I-type ADDI is immediate data, so only R-type subtracts.
          3'b000:  alu_control_o = (rtype_i && funct7b5_i) ? ALU_SUB : ALU_ADD;
          3'b001:  alu_control_o = ALU_SLL;
          3'b010:  alu_control_o = ALU_SLT;
          3'b011:  alu_control_o = ALU_SLTU;
          3'b100:  alu_control_o = ALU_XOR;
          3'b101:  alu_control_o = funct7b5_i ? ALU_SRA : ALU_SRL;
          3'b110:  alu_control_o = ALU_OR;
          default: alu_control_o = ALU_AND;
        endcase
      end
    endcase
  end

endmodule

`default_nettype wire

// File: rtl/riscv_multi_ctrl.sv
// ============================================================================
// riscv_multi_ctrl : multi-cycle RV32I main FSM with memory wait and trap
// Revision 1.0
// ============================================================================
`default_nettype none

module riscv_multi_ctrl
  import riscv_ctrl_pkg::*;
#(
  parameter int MEM_WAIT_EN = 1,
  parameter int MEM_TIMEOUT = 0,
  parameter int TRAP_EN     = 1
) (
  input  logic       clk,
  input  logic       resetn,
  input  logic [6:0] op,
  input  logic [2:0] funct3,
  input  logic       funct7b5,
  input  logic       Zero,
  input  logic       Lt,
  input  logic       Ltu,
  input  logic       MemReady,
  output logic       PCWrite,
  output logic       IRWrite,
  output logic       MemWrite,
  output logic       RegWrite,
  output logic       AdrSrc,
  output logic       MemReq,
  output logic [1:0] ResultSrc,
  output logic [1:0] ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [2:0] ImmSrc,
  output logic [3:0] ALUControl,
  output logic       Trap,
  output logic [1:0] TrapCause,
  output logic [3:0] State
);

  localparam int CNT_W = (MEM_TIMEOUT > 0) ? $clog2(MEM_TIMEOUT + 1) : 1;

  state_t           state_q, state_d, dispatch;
  ctl_t             ctl_q;
  logic [1:0]       cause_q, cause_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             mem_ready, in_mem, timeout, taken, illegal;

  assign mem_ready = (MEM_WAIT_EN != 0) ? MemReady : 1'b1;
  assign in_mem    = (state_q == S_FETCH) || (state_q == S_MEMREAD) || (state_q == S_MEMWRITE);
  // MemReady in the limit cycle wins: timeout needs the ready to be absent.
  assign timeout   = (MEM_TIMEOUT != 0) && in_mem && !mem_ready &&
                     (cnt_q == CNT_W'(MEM_TIMEOUT - 1));
  assign cnt_d     = ((MEM_TIMEOUT != 0) && in_mem && !mem_ready) ? cnt_q + 1'b1 : '0;

  always_comb begin
    illegal  = 1'b0;
    dispatch = S_FETCH;
    case (op)
      OP_LOAD, OP_STORE: dispatch = S_MEMADR;
      OP_R:              dispatch = S_EXECR;
      OP_I:              dispatch = S_EXECI;
      OP_JAL:            dispatch = S_JAL;
      OP_JALR:           if (funct3 == 3'b000) dispatch = S_JALR; else illegal = 1'b1;
      OP_BRANCH:         if (funct3[2:1] == 2'b01) illegal = 1'b1; else dispatch = S_BRANCH;
      OP_LUI:            dispatch = S_LUI;
      OP_AUIPC:          dispatch = S_AUIPC;
      default:           illegal = 1'b1;
    endcase
  end

  always_comb begin
    case (funct3)
      3'b000:  taken = Zero;
      3'b001:  taken = !Zero;
      3'b100:  taken = Lt;
      3'b101:  taken = !Lt;
      3'b110:  taken = Ltu;
      3'b111:  taken = !Ltu;
      default: taken = 1'b0;
    endcase
  end

  always_comb begin
    state_d = state_q;
    cause_d = cause_q;
    case (state_q)
      S_FETCH:    if (mem_ready) state_d = S_DECODE;
      S_DECODE: begin
        if (!illegal) begin
          state_d = dispatch;
        end else if (TRAP_EN != 0) begin
          state_d = S_TRAP;
          cause_d = CAUSE_ILLEGAL;
        end else begin
          state_d = S_FETCH;
        end
      end
      S_MEMADR:   state_d = (op == OP_STORE) ? S_MEMWRITE : S_MEMREAD;
      S_MEMREAD:  if (mem_ready) state_d = S_MEMWB;
      S_MEMWRITE: if (mem_ready) state_d = S_FETCH;
      S_EXECR, S_EXECI, S_JAL, S_JALR, S_LUI, S_AUIPC: state_d = S_ALUWB;
      S_MEMWB, S_ALUWB, S_BRANCH: state_d = S_FETCH;
      S_TRAP:     state_d = S_TRAP;
      default:    state_d = S_FETCH;
    endcase
    if (timeout) begin
      if (TRAP_EN != 0) begin
        state_d = S_TRAP;
        cause_d = CAUSE_TIMEOUT;
      end else begin
        state_d = S_FETCH;
      end
    end
  end

  // Moore outputs are registered from the next state so they line up with state_q.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q <= S_FETCH;
      ctl_q   <= moore_ctl(S_FETCH);
      cause_q <= CAUSE_NONE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      ctl_q   <= moore_ctl(state_d);
      cause_q <= cause_d;
      cnt_q   <= cnt_d;
    end
  end

  riscv_alu_dec u_alu_dec (
    .alu_op_i      (ctl_q.alu_op),
    .funct3_i      (funct3),
    .funct7b5_i    (funct7b5),
    .rtype_i       (op == OP_R),
    .alu_control_o (ALUControl)
  );

  assign IRWrite   = resetn && (state_q == S_FETCH) && mem_ready;
  assign MemWrite  = resetn && (state_q == S_MEMWRITE) && mem_ready;
  assign PCWrite   = resetn && (ctl_q.pc_write || ((state_q == S_FETCH) && mem_ready) ||
                                ((state_q == S_BRANCH) && taken));
  assign RegWrite  = ctl_q.reg_write;
  assign AdrSrc    = ctl_q.adr_src;
  assign MemReq    = ctl_q.mem_req;
  assign ResultSrc = ctl_q.result_src;
  assign ALUSrcA   = ctl_q.src_a;
  assign ALUSrcB   = ctl_q.src_b;
  assign ImmSrc    = imm_src(op);
  assign Trap      = ctl_q.trap;
  assign TrapCause = cause_q;
  assign State     = state_q;

endmodule

`default_nettype wire

// File: tb/tb_riscv_multi_ctrl.sv
// ============================================================================
// tb_riscv_multi_ctrl : per-cycle scoreboard bench for riscv_multi_ctrl
// Revision 1.0
// ============================================================================
`default_nettype none

module tb_riscv_multi_ctrl;
  import riscv_ctrl_pkg::*;

  logic clk = 1'b0;
  logic resetn;
  logic [6:0] op;
  logic [2:0] funct3;
  logic funct7b5, Zero, Lt, Ltu, MemReady;
  logic PCWrite, IRWrite, MemWrite, RegWrite, AdrSrc, MemReq, Trap;
  logic [1:0] ResultSrc, ALUSrcA, ALUSrcB, TrapCause;
  logic [2:0] ImmSrc;
  logic [3:0] ALUControl, State;

  riscv_multi_ctrl #(.MEM_WAIT_EN(1), .MEM_TIMEOUT(8), .TRAP_EN(1)) dut (
    .clk(clk), .resetn(resetn), .op(op), .funct3(funct3), .funct7b5(funct7b5),
    .Zero(Zero), .Lt(Lt), .Ltu(Ltu), .MemReady(MemReady),
    .PCWrite(PCWrite), .IRWrite(IRWrite), .MemWrite(MemWrite), .RegWrite(RegWrite),
    .AdrSrc(AdrSrc), .MemReq(MemReq), .ResultSrc(ResultSrc), .ALUSrcA(ALUSrcA),
    .ALUSrcB(ALUSrcB), .ImmSrc(ImmSrc), .ALUControl(ALUControl), .Trap(Trap),
    .TrapCause(TrapCause), .State(State)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [3:0] st;
    logic       pcw, irw, mw, rw, mreq, adr;
    logic [1:0] res, sa, sb;
    logic [3:0] alu;
    logic [2:0] imm;
    logic       trap;
    logic [1:0] cause;
  } vec_t;

  typedef struct {
    string name;
    vec_t  e;
    vec_t  m;
  } chk_t;

  chk_t q[$];
  int n_chk = 0;
  int n_pass = 0;
  logic [1:0] exp_cause;
  logic [2:0] exp_imm;
  bit imm_care;

  // Monitor: every cycle the stimulus has queued an expectation, compare on negedge.
  always @(negedge clk) begin
    chk_t c;
    vec_t a;
    if (q.size() > 0) begin
      c = q.pop_front();
      a = {State, PCWrite, IRWrite, MemWrite, RegWrite, MemReq, AdrSrc, ResultSrc,
           ALUSrcA, ALUSrcB, ALUControl, ImmSrc, Trap, TrapCause};
      n_chk++;
      if (((a ^ c.e) & c.m) == '0) n_pass++;
      else $display("FAIL %s: got %h required %h (care mask %h)", c.name, a, c.e, c.m);
    end
  end

  task automatic ins(input logic [6:0] o, input logic [2:0] f3, input logic f7,
                     input logic [2:0] im, input bit ic);
    op = o; funct3 = f3; funct7b5 = f7; exp_imm = im; imm_care = ic;
  endtask

  // One cycle: drive MemReady, queue the spec-derived expectation, advance.
  task automatic cyc(input string n, input logic [3:0] s, input bit rdy, input bit pcw,
                     input int alu);
    chk_t c;
    vec_t e, m;
    MemReady = rdy;
    e = '0; m = '0;
    e.st = s; e.pcw = pcw;
    e.irw = (s == S_FETCH) && rdy;
    e.mw  = (s == S_MEMWRITE) && rdy;
    e.rw  = (s == S_MEMWB) || (s == S_ALUWB);
    e.mreq = (s == S_FETCH) || (s == S_MEMREAD) || (s == S_MEMWRITE);
    e.trap = (s == S_TRAP);
    e.cause = exp_cause;
    e.imm = exp_imm;
    m.st = '1; m.pcw = 1; m.irw = 1; m.mw = 1; m.rw = 1; m.mreq = 1; m.trap = 1; m.cause = '1;
    m.imm = imm_care ? 3'b111 : 3'b000;
    case (s)
      S_FETCH:    begin e.adr = 0; e.res = 2'b10; e.sa = 2'b00; e.sb = 2'b10; e.alu = ALU_ADD;
                        m.adr = 1; m.res = '1; m.sa = '1; m.sb = '1; m.alu = '1; end
      S_DECODE:   begin e.sa = 2'b01; e.sb = 2'b01; e.alu = ALU_ADD; m.sa = '1; m.sb = '1; m.alu = '1; end
      S_MEMADR:   begin e.sa = 2'b10; e.sb = 2'b01; e.alu = ALU_ADD; m.sa = '1; m.sb = '1; m.alu = '1; end
      S_MEMREAD,
      S_MEMWRITE: begin e.adr = 1; e.res = 2'b00; m.adr = 1; m.res = '1; end
      S_MEMWB:    begin e.res = 2'b01; m.res = '1; end
      S_EXECR:    begin e.sa = 2'b10; e.sb = 2'b00; m.sa = '1; m.sb = '1; end
      S_EXECI:    begin e.sa = 2'b10; e.sb = 2'b01; m.sa = '1; m.sb = '1; end
      S_ALUWB:    begin e.res = 2'b00; m.res = '1; end
      S_JAL:      begin e.sa = 2'b01; e.sb = 2'b10; e.res = 2'b00; e.alu = ALU_ADD;
                        m.sa = '1; m.sb = '1; m.res = '1; m.alu = '1; end
      S_JALR:     begin e.sa = 2'b10; e.sb = 2'b01; e.res = 2'b10; e.alu = ALU_ADD;
                        m.sa = '1; m.sb = '1; m.res = '1; m.alu = '1; end
      S_BRANCH:   begin e.sa = 2'b10; e.sb = 2'b00; e.res = 2'b00; e.alu = ALU_SUB;
                        m.sa = '1; m.sb = '1; m.res = '1; m.alu = '1; end
      S_LUI:      begin e.sb = 2'b01; e.alu = ALU_ADD; m.sb = '1; m.alu = '1; end
      S_AUIPC:    begin e.sa = 2'b01; e.sb = 2'b01; e.alu = ALU_ADD; m.sa = '1; m.sb = '1; m.alu = '1; end
      default:    ;
    endcase
    if (alu >= 0) begin e.alu = alu[3:0]; m.alu = '1; end
    c.name = n; c.e = e; c.m = m;
    q.push_back(c);
    @(posedge clk); #1;
  endtask

  task automatic do_reset(input string n);
    chk_t c;
    resetn = 1'b0; MemReady = 1'b1; exp_cause = CAUSE_NONE;
    c.name = n; c.e = '0; c.m = '0;
    c.e.st = S_FETCH; c.m.st = '1;
    c.m.pcw = 1; c.m.irw = 1; c.m.mw = 1; c.m.rw = 1; c.m.trap = 1; c.m.cause = '1;
    q.push_back(c);
    @(posedge clk); #1;
    resetn = 1'b1;
  endtask

  task automatic alu_instr(input string n, input logic [6:0] o, input logic [2:0] f3,
                           input logic f7, input logic [3:0] alu);
    logic [3:0] ex;
    ex = (o == OP_R) ? S_EXECR : S_EXECI;
    ins(o, f3, f7, IMM_I, o != OP_R);
    cyc({n, "_fetch"}, S_FETCH, 1, 1, -1);
    cyc({n, "_decode"}, S_DECODE, 1, 0, -1);
    cyc({n, "_exec"}, ex, 1, 0, int'(alu));
    cyc({n, "_wb"}, S_ALUWB, 1, 0, -1);
  endtask

  task automatic branch(input string n, input logic [2:0] f3, input bit z, input bit lt,
                        input bit ltu, input bit tk);
    ins(OP_BRANCH, f3, 0, IMM_B, 1);
    Zero = z; Lt = lt; Ltu = ltu;
    cyc({n, "_fetch"}, S_FETCH, 1, 1, -1);
    cyc({n, "_decode"}, S_DECODE, 1, 0, -1);
    cyc({n, "_branch"}, S_BRANCH, 1, tk, -1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation still running, required finish");
    $fatal(1);
  end

  initial begin
    resetn = 1'b0; MemReady = 1'b1; Zero = 0; Lt = 0; Ltu = 0;
    exp_cause = CAUSE_NONE;
    ins(OP_R, 3'b000, 1'b1, IMM_I, 0);
    repeat (2) @(posedge clk);
    #1;
    do_reset("reset");

    alu_instr("sub",  OP_R, 3'b000, 1'b1, ALU_SUB);
    alu_instr("xor",  OP_R, 3'b100, 1'b0, ALU_XOR);
    alu_instr("sltu", OP_R, 3'b011, 1'b0, ALU_SLTU);
    alu_instr("addi", OP_I, 3'b000, 1'b1, ALU_ADD);
    alu_instr("srai", OP_I, 3'b101, 1'b1, ALU_SRA);

    ins(OP_LOAD, 3'b010, 0, IMM_I, 1);
    cyc("lw_fetch", S_FETCH, 1, 1, -1);
    cyc("lw_decode", S_DECODE, 1, 0, -1);
    cyc("lw_memadr", S_MEMADR, 1, 0, -1);
    for (int i = 0; i < 3; i++) cyc("lw_wait", S_MEMREAD, 0, 0, -1);
    cyc("lw_memread", S_MEMREAD, 1, 0, -1);
    cyc("lw_memwb", S_MEMWB, 1, 0, -1);

    ins(OP_STORE, 3'b010, 0, IMM_S, 1);
    cyc("sw_fetch", S_FETCH, 1, 1, -1);
    cyc("sw_decode", S_DECODE, 1, 0, -1);
    cyc("sw_memadr", S_MEMADR, 1, 0, -1);
    cyc("sw_wait", S_MEMWRITE, 0, 0, -1);
    cyc("sw_memwrite", S_MEMWRITE, 1, 0, -1);

    branch("bne_nz",  3'b001, 0, 0, 0, 1);
    branch("bne_z",   3'b001, 1, 0, 0, 0);
    branch("bltu_t",  3'b110, 0, 0, 1, 1);
    branch("bge_nt",  3'b101, 0, 1, 0, 0);
    branch("beq_t",   3'b000, 1, 0, 0, 1);

    ins(OP_JAL, 3'b000, 0, IMM_J, 1);
    cyc("jal_fetch", S_FETCH, 1, 1, -1);
    cyc("jal_decode", S_DECODE, 1, 0, -1);
    cyc("jal_jal", S_JAL, 1, 1, -1);
    cyc("jal_wb", S_ALUWB, 1, 0, -1);

    // MemReady arrives in the eighth wait cycle, exactly at the timeout limit.
    ins(OP_JALR, 3'b000, 0, IMM_I, 1);
    for (int i = 0; i < 7; i++) cyc("jalr_fwait", S_FETCH, 0, 0, -1);
    cyc("jalr_fetch_limit", S_FETCH, 1, 1, -1);
    cyc("jalr_decode", S_DECODE, 1, 0, -1);
    cyc("jalr_jalr", S_JALR, 1, 1, -1);
    cyc("jalr_wb", S_ALUWB, 1, 0, -1);

    ins(OP_LUI, 3'b000, 0, IMM_U, 1);
    cyc("lui_fetch", S_FETCH, 1, 1, -1);
    cyc("lui_decode", S_DECODE, 1, 0, -1);
    cyc("lui_lui", S_LUI, 1, 0, -1);
    cyc("lui_wb", S_ALUWB, 1, 0, -1);

    ins(OP_AUIPC, 3'b000, 0, IMM_U, 1);
    cyc("auipc_fetch", S_FETCH, 1, 1, -1);
    cyc("auipc_decode", S_DECODE, 1, 0, -1);
    cyc("auipc_auipc", S_AUIPC, 1, 0, -1);
    cyc("auipc_wb", S_ALUWB, 1, 0, -1);

    ins(7'b1111111, 3'b000, 0, IMM_I, 0);
    cyc("ill_fetch", S_FETCH, 1, 1, -1);
    cyc("ill_decode", S_DECODE, 1, 0, -1);
    exp_cause = CAUSE_ILLEGAL;
    for (int i = 0; i < 3; i++) cyc("ill_trap", S_TRAP, 1, 0, -1);

    do_reset("reset_after_trap");
    ins(OP_R, 3'b000, 0, IMM_I, 0);
    for (int i = 0; i < 8; i++) cyc("to_fwait", S_FETCH, 0, 0, -1);
    exp_cause = CAUSE_TIMEOUT;
    cyc("to_trap", S_TRAP, 0, 0, -1);
    cyc("to_trap_rdy", S_TRAP, 1, 0, -1);

    repeat (2) @(negedge clk);
    n_chk++;
    if (q.size() == 0) n_pass++;
    else $display("FAIL drain: got %0d pending expectations required 0", q.size());

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

`default_nettype wire
